l2_dram_if: RTL and testbench
=============================

L2_DRAM_IF -- requirements
Module: l2_dram_if

Interface
REQ-001 SHALL have parameter BEATS, default 8, meaning 64-bit data beats per read burst (one cache line).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning clk cycles allowed between consecutive strobe events before abort.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  L2 request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_write  input  1  0 = line fill (READ), 1 = writeback (WRITE).
REQ-008 SHALL have port req_addr  input  32  line address.
REQ-009 SHALL have port L2cmd  output  1  command to DRAM; READ = 0, WRITE = 1.
REQ-010 SHALL have port L2addr  output  32  address to DRAM.
REQ-011 SHALL have port mem_req  output  1  command valid to DRAM.
REQ-012 SHALL have port L2data  input  64  DRAM read data, stable whenever strobe toggles.
REQ-013 SHALL have port strobe  input  1  DRAM handshake; every level change (either edge) is one event.
REQ-014 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-015 SHALL have port resp_line  output  64*BEATS  assembled line; beat k in bits [64k+63:64k].
REQ-016 SHALL have port resp_err  output  1  completion was a timeout abort.

Function
REQ-017 SHALL pass strobe through a 2-flop synchronizer; one event SHALL be registered when the synchronized value differs from its previous-cycle value.
REQ-018 SHALL sample L2data through a matching 2-stage delay so the captured beat aligns with its event.
REQ-019 SHALL implement FSM states IDLE, ISSUE, RDATA, WACK, DONE.
REQ-020 IDLE: req_ready=1; on req_valid SHALL latch req_write/req_addr, drive L2cmd/L2addr, and go to ISSUE.
REQ-021 ISSUE: mem_req=1 for exactly one cycle; next state SHALL be RDATA if READ, WACK if WRITE; the beat counter SHALL clear.
REQ-022 L2cmd/L2addr SHALL hold their values from ISSUE until DONE exits.
REQ-023 RDATA: each event SHALL write the captured beat into slot[beat counter] and increment it; after the BEATS-th event SHALL go to DONE.
REQ-024 Events after BEATS beats, or in IDLE/ISSUE/DONE, SHALL be ignored without changing resp_line.
REQ-025 WACK: the first event SHALL go to DONE; resp_line SHALL be unchanged.
REQ-026 DONE: resp_valid=1 for one cycle, then IDLE; req_ready=0 in all states except IDLE.
REQ-027 Request-to-DONE latency SHALL be ISSUE (1) + synchronizer delay (2) per event + 1; a request accepted while in DONE is not possible.
REQ-028 The beat counter SHALL be $clog2(BEATS)+1 bits wide and SHALL NOT wrap within a burst.

Reset
REQ-029 While rst=1: state=IDLE, req_ready=0, mem_req=0, L2cmd=0, L2addr=0, resp_valid=0, resp_err=0, resp_line=0, counters and synchronizer=0.
REQ-030 Reset mid-burst SHALL abandon the transfer without resp_valid; events arriving in the first cycle after reset SHALL NOT count.
REQ-031 The synchronizer's previous-value register SHALL load the current synchronized strobe on the first post-reset cycle, so a strobe left high creates no event.

Configuration
REQ-032 Macro L2_DRAM_TIMEOUT_EN: when defined, a watchdog SHALL count cycles in RDATA/WACK since the last event (or ISSUE); on reaching TIMEOUT SHALL go to DONE with resp_err=1 alongside resp_valid; partial beats SHALL remain in resp_line.
REQ-033 Without L2_DRAM_TIMEOUT_EN: no watchdog logic; resp_err SHALL be tied 0; the block SHALL wait indefinitely.

Verification
REQ-034 Read addr 0x1000, DRAM toggles strobe 8x with data 0x1000+64k -> one mem_req pulse, L2cmd=0, resp_valid once, resp_line beat k = 0x1000+64k, resp_err=0.
REQ-035 Write addr 0x2040, one strobe toggle -> L2cmd=1, L2addr=0x2040, resp_valid one cycle, resp_line unchanged.
REQ-036 Read, then 10 extra toggles after beat 8 -> resp_line beats unchanged; no second resp_valid.
REQ-037 rst asserted after beat 3 of read -> outputs at reset values, no resp_valid; next read completes normally.
REQ-038 With L2_DRAM_TIMEOUT_EN, TIMEOUT=20, read stalls after 5 beats -> resp_valid with resp_err=1 at 20 cycles after the 5th event; beats 0-4 valid.
REQ-039 req_valid held high continuously with back-to-back bursts -> next ISSUE occurs only after returning to IDLE (req_ready=1); no request lost or duplicated.

Source files
------------

// File: rtl/l2_dram_if_if.sv
// Bundle of L2-side request/response and DRAM-side command/strobe signals for l2_dram_if.
// slave = the bridge itself; master = the L2 controller and DRAM pair driving it.
interface l2_dram_if_if #(
    parameter int unsigned BEATS = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic                  L2cmd;
    logic [31:0]           L2addr;
    logic                  mem_req;
    logic [63:0]           L2data;
    logic                  strobe;
    logic                  resp_valid;
    logic [64*BEATS-1:0]   resp_line;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_write, req_addr, L2data, strobe,
        output req_ready, L2cmd, L2addr, mem_req, resp_valid, resp_line, resp_err
    );

    modport master (
        output req_valid, req_write, req_addr, L2data, strobe,
        input  req_ready, L2cmd, L2addr, mem_req, resp_valid, resp_line, resp_err
    );
endinterface

// File: rtl/l2_dram_if.sv
// L2 <-> DRAM bridge: one command per request, read bursts assembled from strobe-toggle beats.
// Optional watchdog abort is enabled by defining L2_DRAM_TIMEOUT_EN.
module l2_dram_if #(
    parameter int unsigned BEATS   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    l2_dram_if_if.slave  bus
);
    localparam int unsigned CW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StRdata, StWack, StDone} state_e;

    state_e              state_q, state_d;
    logic                strobe_s1_q, strobe_s2_q, strobe_prev_q;
    logic [1:0]          arm_q;
    logic [63:0]         data_s1_q, data_s2_q;
    logic                evt;
    logic                cmd_q, cmd_d;
    logic [31:0]         addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [64*BEATS-1:0] line_q, line_d;

    // Data rides a pipeline as deep as the strobe synchronizer so beat and event line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_s1_q   <= 1'b0;
            strobe_s2_q   <= 1'b0;
            strobe_prev_q <= 1'b0;
            arm_q         <= 2'd0;
            data_s1_q     <= '0;
            data_s2_q     <= '0;
        end else begin
            strobe_s1_q   <= bus.strobe;
            strobe_s2_q   <= strobe_s1_q;
            strobe_prev_q <= strobe_s2_q;
            data_s1_q     <= bus.L2data;
            data_s2_q     <= data_s1_q;
            if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
        end
    end

    // Edges are masked until the synchronizer has refilled, so a level held across reset is silent.
    assign evt = (arm_q == 2'd3) && (strobe_s2_q != strobe_prev_q);

`ifdef L2_DRAM_TIMEOUT_EN
    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = |32'(TIMEOUT);
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
`ifdef L2_DRAM_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    cmd_d   = bus.req_write;
                    addr_d  = bus.req_addr;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = cmd_q ? StWack : StRdata;
            end
            StRdata: begin
                if (evt && (cnt_q < CW'(BEATS))) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CW'(k)) line_d[64*k +: 64] = data_s2_q;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LastBeat) state_d = StDone;
                end
            end
            StWack: begin
                if (evt) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef L2_DRAM_TIMEOUT_EN
        if (state_q == StIssue) begin
            wd_d  = '0;
            err_d = 1'b0;
        end else if ((state_q == StRdata) || (state_q == StWack)) begin
            if (evt) begin
                wd_d = '0;
            end else if (wd_q == WdLast) begin
                state_d = StDone;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
`ifdef L2_DRAM_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
`ifdef L2_DRAM_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    // State-decoded outputs are gated by rst so they read as idle during the reset cycle itself.
    assign bus.req_ready  = !rst && (state_q == StIdle);
    assign bus.mem_req    = !rst && (state_q == StIssue);
    assign bus.resp_valid = !rst && (state_q == StDone);
    assign bus.L2cmd      = cmd_q;
    assign bus.L2addr     = addr_q;
    assign bus.resp_line  = line_q;
`ifdef L2_DRAM_TIMEOUT_EN
    assign bus.resp_err   = !rst && (state_q == StDone) && err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_l2_dram_if.sv
// Directed bench for l2_dram_if: read/write bursts, overrun, mid-burst reset, back-to-back requests.
module tb_l2_dram_if;
    localparam int unsigned BEATS   = 8;
    localparam int unsigned TIMEOUT = 20;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   rv_cnt;
    int   mr_cnt;

    l2_dram_if_if #(.BEATS(BEATS)) bus ();

    l2_dram_if #(.BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sample pre-edge values at each rising edge.
    always @(posedge clk) begin
        if (bus.resp_valid) rv_cnt <= rv_cnt + 1;
        if (bus.mem_req)    mr_cnt <= mr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered on a falling edge; leaves two falling edges later.
    task automatic toggle(input logic [63:0] data);
        bus.L2data = data;
        bus.strobe = ~bus.strobe;
        repeat (2) @(negedge clk);
    endtask

    task automatic serve(input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++) toggle(base + 64'(64 * k));
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int limit, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 64'(seen), 64'd1);
    endtask

    task automatic check_line(input string tag, input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++)
            check_eq($sformatf("%s_beat%0d", tag, k), bus.resp_line[64*k +: 64],
                     base + 64'(64 * k));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
        check_eq({tag, "_memreq"}, 64'(bus.mem_req), 64'd0);
        check_eq({tag, "_rvalid"}, 64'(bus.resp_valid), 64'd0);
        check_eq({tag, "_err"}, 64'(bus.resp_err), 64'd0);
        check_eq({tag, "_cmd"}, 64'(bus.L2cmd), 64'd0);
        check_eq({tag, "_addr"}, 64'(bus.L2addr), 64'd0);
        check_eq({tag, "_line"}, 64'(|bus.resp_line), 64'd0);
    endtask

    initial begin
        int cyc;
        int rv0;
        int mr0;
        n_total = 0;
        n_bad   = 0;
        rv_cnt  = 0;
        mr_cnt  = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.L2data    = '0;
        bus.strobe    = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_ready", 64'(bus.req_ready), 64'd1);

        // Line fill of 0x1000
        issue(1'b0, 32'h1000);
        check_eq("rd1_memreq", 64'(bus.mem_req), 64'd1);
        check_eq("rd1_cmd", 64'(bus.L2cmd), 64'd0);
        check_eq("rd1_addr", 64'(bus.L2addr), 64'h1000);
        check_eq("rd1_ready", 64'(bus.req_ready), 64'd0);
        serve(64'h1000, 8);
        wait_resp("rd1_resp", 10, cyc);
        check_eq("rd1_err", 64'(bus.resp_err), 64'd0);
        check_line("rd1", 64'h1000, 8);
        repeat (2) @(negedge clk);
        check_eq("rd1_rvcnt", 64'(rv_cnt), 64'd1);
        check_eq("rd1_mrcnt", 64'(mr_cnt), 64'd1);

        // Overrun: extra toggles after the line completed
        for (int k = 0; k < 10; k++) toggle(64'hdead_0000 + 64'(k));
        repeat (4) @(negedge clk);
        check_line("ovr", 64'h1000, 8);
        check_eq("ovr_rvcnt", 64'(rv_cnt), 64'd1);
        check_eq("ovr_ready", 64'(bus.req_ready), 64'd1);

        // Writeback to 0x2040
        issue(1'b1, 32'h2040);
        check_eq("wr_memreq", 64'(bus.mem_req), 64'd1);
        check_eq("wr_cmd", 64'(bus.L2cmd), 64'd1);
        check_eq("wr_addr", 64'(bus.L2addr), 64'h2040);
        toggle(64'hffff_ffff);
        wait_resp("wr_resp", 10, cyc);
        check_eq("wr_addr_hold", 64'(bus.L2addr), 64'h2040);
        check_eq("wr_cmd_hold", 64'(bus.L2cmd), 64'd1);
        check_line("wr", 64'h1000, 8);
        @(negedge clk);
        check_eq("wr_pulse_end", 64'(bus.resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("wr_rvcnt", 64'(rv_cnt), 64'd2);

        // Reset after three beats of a read
        rv0 = rv_cnt;
        issue(1'b0, 32'h3000);
        serve(64'h3000, 3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst1");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("rst1_rvcnt", 64'(rv_cnt), 64'(rv0));
        check_eq("rst1_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst1_line", 64'(|bus.resp_line), 64'd0);
        issue(1'b0, 32'h4000);
        check_eq("rd2_addr", 64'(bus.L2addr), 64'h4000);
        serve(64'h4000, 8);
        wait_resp("rd2_resp", 10, cyc);
        check_line("rd2", 64'h4000, 8);

        // Back-to-back with req_valid held high
        repeat (2) @(negedge clk);
        mr0 = mr_cnt;
        rv0 = rv_cnt;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h5000;
        @(negedge clk);
        check_eq("b2b_memreq1", 64'(bus.mem_req), 64'd1);
        bus.req_addr = 32'h6000;
        serve(64'h5000, 8);
        wait_resp("b2b_resp1", 10, cyc);
        check_line("b2b1", 64'h5000, 8);
        check_eq("b2b_done_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check_eq("b2b_idle_ready", 64'(bus.req_ready), 64'd1);
        check_eq("b2b_idle_memreq", 64'(bus.mem_req), 64'd0);
        @(negedge clk);
        check_eq("b2b_memreq2", 64'(bus.mem_req), 64'd1);
        check_eq("b2b_addr2", 64'(bus.L2addr), 64'h6000);
        bus.req_valid = 1'b0;
        serve(64'h6000, 8);
        wait_resp("b2b_resp2", 10, cyc);
        check_line("b2b2", 64'h6000, 8);
        repeat (3) @(negedge clk);
        check_eq("b2b_mrcnt", 64'(mr_cnt - mr0), 64'd2);
        check_eq("b2b_rvcnt", 64'(rv_cnt - rv0), 64'd2);

`ifdef L2_DRAM_TIMEOUT_EN
        // Stall after five beats: abort 20 cycles after the fifth event is taken
        issue(1'b0, 32'h7000);
        serve(64'h7000, 4);
        bus.L2data = 64'h7000 + 64'(64 * 4);
        bus.strobe = ~bus.strobe;
        wait_resp("to_resp", 40, cyc);
        check_eq("to_latency", 64'(cyc), 64'd23);
        check_eq("to_err", 64'(bus.resp_err), 64'd1);
        check_line("to", 64'h7000, 5);
        @(negedge clk);
        check_eq("to_err_end", 64'(bus.resp_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
